// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch top and its IF/ID register.
package fetch_pkg;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Sequential successor of a fetch address; wraps silently at the top of memory.
   function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request bus: fetch drives req/addr, memory answers with rdata/ready.
// ready qualifies rdata for the address presented in the same cycle.
interface instr_fetch_if #(
   parameter int DATA_WIDTH = 32
);

   logic                  imem_req;
   logic [DATA_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_rdata;
   logic                  imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear beats load beats hold; one-cycle latency from load to outputs.
// The owner deasserts load to hold the contents while decode is stalled.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] d_instr,
   input  logic [DATA_WIDTH-1:0] d_pc,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  valid_out
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   // Clearing only drops the valid bit; the stale word and PC are harmless once invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr     <= DATA_WIDTH'(NOP_INSTR);
         pc_out    <= '0;
         valid_out <= 1'b0;
      end else if (clear) begin
         valid_out <= 1'b0;
      end else if (load) begin
         instr     <= d_instr;
         pc_out    <= d_pc;
         valid_out <= 1'b1;
      end
   end

   assign pc_plus4 = pc_out + PC_STEP;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, imem request FSM and a one-entry skid buffer; a word accepted at edge N is on instr after N.
// A stall while a word returns parks it in the skid buffer and suspends requests until decode frees up.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  PCsrc,
   input  logic [DATA_WIDTH-1:0] ImmOp,
   input  logic                  stall,
   input  logic                  flush,
   instr_fetch_if.master         imem,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  valid_out
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   fetch_state_t          state;
   fetch_state_t          state_nxt;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] target;
   logic [DATA_WIDTH-1:0] skid_instr;
   logic [DATA_WIDTH-1:0] skid_pc;
   logic                  skid_vld;
   logic                  redirect;
   logic                  accept;
   logic                  ifid_load;
   logic                  ifid_clear;
   logic [DATA_WIDTH-1:0] ifid_instr_d;
   logic [DATA_WIDTH-1:0] ifid_pc_d;

   // A branch sitting in an invalid IF/ID slot is a bubble, so its PCsrc means nothing.
   assign redirect = PCsrc & valid_out;
   assign target   = pc_out + ImmOp;
   assign accept   = (state == FETCH) & imem.imem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (redirect || flush) begin
         state_nxt = FETCH;
      end else begin
         case (state)
            FETCH:   if (accept && stall) state_nxt = HOLD;
            HOLD:    if (!stall)          state_nxt = FETCH;
            default:                      state_nxt = FETCH;
         endcase
      end
   end

   always_comb begin
      ifid_load    = 1'b0;
      ifid_clear   = 1'b0;
      ifid_instr_d = imem.imem_rdata;
      ifid_pc_d    = pc;
      if (redirect || flush) begin
         ifid_clear = 1'b1;
      end else if (!stall) begin
         case (state)
            FETCH: begin
               ifid_load  = imem.imem_ready;
               ifid_clear = !imem.imem_ready;
            end
            HOLD: begin
               ifid_load    = skid_vld;
               ifid_clear   = !skid_vld;
               ifid_instr_d = skid_instr;
               ifid_pc_d    = skid_pc;
            end
            default: ifid_clear = 1'b1;
         endcase
      end
   end

   assign imem.imem_req  = rst_n & (state == FETCH);
   assign imem.imem_addr = pc;

   // The PC advances on every accepted word, even one that a flush throws away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= target;
      end else if (accept) begin
         pc <= pc + PC_STEP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_vld   <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else if (redirect || flush) begin
         skid_vld <= 1'b0;
      end else if (accept && stall) begin
         skid_vld   <= 1'b1;
         skid_instr <= imem.imem_rdata;
         skid_pc    <= pc;
      end else if (state == HOLD && !stall) begin
         skid_vld <= 1'b0;
      end
   end

   if_id_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_if_id (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ifid_load),
      .clear     (ifid_clear),
      .d_instr   (ifid_instr_d),
      .d_pc      (ifid_pc_d),
      .instr     (instr),
      .pc_out    (pc_out),
      .pc_plus4  (pc_plus4),
      .valid_out (valid_out)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a long random run against a queue-based model
// of the fetched-but-not-retired instruction stream.
module tb_instr_fetch;
   import fetch_pkg::*;

   localparam int DW = 32;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] dat;
      logic        ld;   // word is in IF/ID rather than waiting in the skid buffer
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        PCsrc;
   logic [31:0] ImmOp;
   logic        stall;
   logic        flush;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        valid_out;
   logic [31:0] data_xor;

   int          total = 0;
   int          bad = 0;
   int          retired = 0;
   ent_t        q[$];
   logic [31:0] exp_fetch;

   instr_fetch_if #(.DATA_WIDTH(DW)) bus ();

   // Memory returns a word derived from the address so every fetch is identifiable.
   assign bus.imem_rdata = bus.imem_addr ^ data_xor;

   always #5 clk = ~clk;

   instr_fetch #(
      .DATA_WIDTH (DW),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .PCsrc     (PCsrc),
      .ImmOp     (ImmOp),
      .stall     (stall),
      .flush     (flush),
      .imem      (bus),
      .instr     (instr),
      .pc_out    (pc_out),
      .pc_plus4  (pc_plus4),
      .valid_out (valid_out)
   );

   // Reference model: checks outputs for this cycle, then applies the coming edge.
   task automatic model_step();
      logic        exp_valid;
      logic        exp_req;
      logic        redir;
      logic        acc;
      logic [31:0] fa;
      ent_t        e;
      exp_valid = (q.size() > 0) && q[0].ld;
      exp_req   = !((q.size() > 0) && !q[q.size()-1].ld);
      fa        = exp_fetch;
      total++; if (bus.imem_addr !== fa) begin bad++; $display("FAIL model_addr: got %h want %h t=%0t", bus.imem_addr, fa, $time); end
      total++; if (bus.imem_req !== exp_req) begin bad++; $display("FAIL model_req: got %b want %b t=%0t", bus.imem_req, exp_req, $time); end
      total++; if (valid_out !== exp_valid) begin bad++; $display("FAIL model_valid: got %b want %b t=%0t", valid_out, exp_valid, $time); end
      if (exp_valid) begin
         total++; if ({pc_out, instr} !== {q[0].pc, q[0].dat}) begin bad++; $display("FAIL model_ifid: got pc=%h instr=%h want pc=%h instr=%h t=%0t", pc_out, instr, q[0].pc, q[0].dat, $time); end
         total++; if (pc_plus4 !== q[0].pc + 32'd4) begin bad++; $display("FAIL model_pc_plus4: got %h want %h t=%0t", pc_plus4, q[0].pc + 32'd4, $time); end
      end
      redir = PCsrc && exp_valid;
      acc   = exp_req && bus.imem_ready;
      if (redir) begin
         exp_fetch = q[0].pc + ImmOp;
         q.delete();
      end else begin
         if (acc) exp_fetch = fa + 32'd4;
         if (flush) begin
            q.delete();
         end else begin
            if (exp_valid && !stall) begin
               void'(q.pop_front());
               retired++;
            end
            if (!stall && q.size() > 0 && !q[0].ld) begin
               e = q.pop_front();
               e.ld = 1'b1;
               q.push_front(e);
            end
            if (acc) begin
               e.pc  = fa;
               e.dat = fa ^ data_xor;
               e.ld  = !stall;
               q.push_back(e);
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rst_n) model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic st, input logic rdy, input logic fl, input logic br, input logic [31:0] imm);
      stall          = st;
      bus.imem_ready = rdy;
      flush          = fl;
      PCsrc          = br;
      ImmOp          = imm;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      data_xor = 32'h0;
      set_in(0, 0, 0, 0, 32'h0);
      q.delete();
      exp_fetch = 32'h0;
      @(negedge clk);
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid_out); end
      total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr: got %h want 00000013", instr); end
      total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc_out: got %h want 0", pc_out); end
      total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL rst_pc_plus4: got %h want 4", pc_plus4); end
      total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rst_release_req: got %b want 1", bus.imem_req); end
   endtask

   task automatic test_sequential();
      set_in(0, 1, 0, 0, 32'h0);
      tick();
      total++; if ({valid_out, instr, bus.imem_addr} !== {1'b1, 32'h0, 32'h4}) begin bad++; $display("FAIL seq_first: got v=%b instr=%h addr=%h want v=1 instr=0 addr=4", valid_out, instr, bus.imem_addr); end
      tick();
      total++; if ({valid_out, instr, bus.imem_addr} !== {1'b1, 32'h4, 32'h8}) begin bad++; $display("FAIL seq_second: got v=%b instr=%h addr=%h want v=1 instr=4 addr=8", valid_out, instr, bus.imem_addr); end
   endtask

   task automatic test_stall();
      set_in(1, 1, 0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if ({bus.imem_req, instr, bus.imem_addr} !== {1'b0, 32'h4, 32'hC}) begin bad++; $display("FAIL stall_hold%0d: got req=%b instr=%h addr=%h want req=0 instr=4 addr=c", i, bus.imem_req, instr, bus.imem_addr); end
      end
      set_in(0, 1, 0, 0, 32'h0);
      tick();
      total++; if ({valid_out, instr, bus.imem_req} !== {1'b1, 32'h8, 1'b1}) begin bad++; $display("FAIL stall_drain: got v=%b instr=%h req=%b want v=1 instr=8 req=1", valid_out, instr, bus.imem_req); end
      tick();
      total++; if ({valid_out, instr} !== {1'b1, 32'hC}) begin bad++; $display("FAIL stall_next: got v=%b instr=%h want v=1 instr=c", valid_out, instr); end
   endtask

   task automatic test_redirect();
      tick();
      total++; if ({valid_out, pc_out, pc_plus4} !== {1'b1, 32'h10, 32'h14}) begin bad++; $display("FAIL redir_setup: got v=%b pc=%h pc4=%h want v=1 pc=10 pc4=14", valid_out, pc_out, pc_plus4); end
      set_in(0, 1, 0, 1, 32'hFFFF_FFF8);
      tick();
      total++; if ({bus.imem_addr, valid_out} !== {32'h8, 1'b0}) begin bad++; $display("FAIL redir_target: got addr=%h v=%b want addr=8 v=0", bus.imem_addr, valid_out); end
      set_in(0, 1, 0, 0, 32'h0);
      tick();
      total++; if ({valid_out, pc_out, instr} !== {1'b1, 32'h8, 32'h8}) begin bad++; $display("FAIL redir_first: got v=%b pc=%h instr=%h want v=1 pc=8 instr=8", valid_out, pc_out, instr); end
   endtask

   task automatic test_pcsrc_invalid();
      set_in(0, 0, 0, 0, 32'h0);
      tick();
      total++; if ({valid_out, bus.imem_addr} !== {1'b0, 32'hC}) begin bad++; $display("FAIL inv_bubble: got v=%b addr=%h want v=0 addr=c", valid_out, bus.imem_addr); end
      set_in(0, 1, 0, 1, 32'h100);
      tick();
      total++; if ({bus.imem_addr, valid_out, pc_out} !== {32'h10, 1'b1, 32'hC}) begin bad++; $display("FAIL inv_ignored: got addr=%h v=%b pc=%h want addr=10 v=1 pc=c", bus.imem_addr, valid_out, pc_out); end
   endtask

   task automatic test_flush_hold();
      set_in(1, 1, 0, 0, 32'h0);
      tick();
      total++; if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'h14}) begin bad++; $display("FAIL flush_enter_hold: got req=%b addr=%h want req=0 addr=14", bus.imem_req, bus.imem_addr); end
      set_in(1, 0, 1, 0, 32'h0);
      tick();
      total++; if ({valid_out, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h14}) begin bad++; $display("FAIL flush_hold: got v=%b req=%b addr=%h want v=0 req=1 addr=14", valid_out, bus.imem_req, bus.imem_addr); end
      set_in(0, 1, 0, 0, 32'h0);
      tick();
      total++; if ({valid_out, pc_out} !== {1'b1, 32'h14}) begin bad++; $display("FAIL flush_skid_empty: got v=%b pc=%h want v=1 pc=14", valid_out, pc_out); end
   endtask

   task automatic test_random();
      int k;
      int start;
      data_xor = 32'hC0DE_0000;
      start    = retired;
      for (int i = 0; i < 2000; i++) begin
         k = int'($urandom_range(0, 31)) - 16;
         set_in($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
                $urandom_range(0, 19) == 0, 32'(k * 4));
         tick();
      end
      set_in(0, 0, 0, 0, 32'h0);
      total++; if (retired - start < 200) begin bad++; $display("FAIL random_progress: got %0d retired want >= 200", retired - start); end
   endtask

   task automatic test_async_reset();
      data_xor = 32'h0;
      set_in(0, 1, 0, 0, 32'h0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({valid_out, instr, pc_out, pc_plus4} !== {1'b0, 32'h0000_0013, 32'h0, 32'h4}) begin bad++; $display("FAIL arst_ifid: got v=%b instr=%h pc=%h pc4=%h want v=0 instr=13 pc=0 pc4=4", valid_out, instr, pc_out, pc_plus4); end
      total++; if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'h0}) begin bad++; $display("FAIL arst_imem: got req=%b addr=%h want req=0 addr=0", bus.imem_req, bus.imem_addr); end
      set_in(0, 0, 0, 0, 32'h0);
      q.delete();
      exp_fetch = 32'h0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL arst_release: got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
      set_in(0, 1, 0, 0, 32'h0);
      tick();
      total++; if ({valid_out, pc_out, instr} !== {1'b1, 32'h0, 32'h0}) begin bad++; $display("FAIL arst_first: got v=%b pc=%h instr=%h want v=1 pc=0 instr=0", valid_out, pc_out, instr); end
      tick();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_pcsrc_invalid();
      test_flush_hold();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the single-issue RISC-V core. It holds the program counter and requests instruction words from instruction memory with a ready handshake. It buffers a word returned while decode is stalled, and presents the instruction, its PC and a valid flag in an IF/ID register. That register feeds decode and `sign_extend`. `sign_extend`'s `ImmOp` output returns here to form branch and jump targets.

## Interface
- `DATA_WIDTH`, 32: instruction, address and PC width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `PCsrc  in  1`: redirect request; taken branch or jump resolved in decode.
- `ImmOp  in  DATA_WIDTH`: sign-extended offset from `sign_extend`.
- `stall  in  1`: decode cannot accept a new instruction; hold the IF/ID register.
- `flush  in  1`: invalidate the IF/ID register contents.
- `imem_req  out  1`: fetch request.
- `imem_addr  out  DATA_WIDTH`: fetch address, always equal to the current PC.
- `imem_rdata  in  DATA_WIDTH`: returned instruction word.
- `imem_ready  in  1`: `imem_rdata` is valid for `imem_addr` this cycle.
- `instr  out  DATA_WIDTH`: IF/ID instruction word, feeds `sign_extend.instr` and decode.
- `pc_out  out  DATA_WIDTH`: PC of `instr`.
- `pc_plus4  out  DATA_WIDTH`: `pc_out + 4`, used as the link value.
- `valid_out  out  1`: `instr` is a real instruction.

## Operation
- Reset values (asynchronous, while `rst_n`=0):
  - PC = `RESET_PC`; FSM = FETCH; skid buffer empty.
  - `instr` = 32'h0000_0013 (NOP, `addi x0,x0,0`); `pc_out` = 0; `pc_plus4` = 4; `valid_out` = 0.
  - `imem_req` is forced 0.
- Redirect target = `pc_out + ImmOp`, modulo 2^DATA_WIDTH with no overflow flag. It is taken only when `PCsrc`=1 and `valid_out`=1; `PCsrc` is ignored when `valid_out`=0.
- FSM states:
  - **FETCH**: `imem_req`=1.
    - `imem_ready`=1 and `stall`=0: load IF/ID with (`imem_rdata`, PC, valid=1); PC += 4; stay in FETCH.
    - `imem_ready`=1 and `stall`=1: write the word and its PC to the skid buffer; PC += 4; go to HOLD.
    - `imem_ready`=0: PC holds. If `stall`=0, `valid_out` clears on the next edge.
  - **HOLD**: `imem_req`=0.
    - `stall`=0: move the skid buffer into IF/ID; go to FETCH.
    - `stall`=1: remain in HOLD.
- Redirect priority (from highest): redirect > `flush` > `stall` > normal fetch. On a taken redirect:
  - PC loads the target.
  - `valid_out` clears and the skid buffer empties.
  - FSM goes to FETCH.
  - Any word accepted in the same cycle is discarded.
- `flush` without a redirect:
  - Clears `valid_out` and empties the skid buffer.
  - The PC is unchanged unless a word is accepted in that same cycle. In that case the PC advances and the word is dropped.
  - The FSM goes to FETCH.
- While `stall`=1 and there is no flush or redirect, `instr`, `pc_out` and `valid_out` hold their values.
- The skid buffer holds one entry; a second word is never requested while it is full.
- PC wrap-around from 32'hFFFF_FFFC to 0 is silent.

## Timing
- Fetch latency: `imem_ready` at edge N puts the word on `instr` with `valid_out`=1 after edge N.
- Throughput: one instruction per cycle with a zero-wait memory.
- Redirect: `PCsrc` high at edge N gives `imem_addr` = target in cycle N+1, and the target instruction is valid after edge N+1.
- `imem_addr` is registered: there is no combinational path from `PCsrc` or `stall` to `imem_addr`. `imem_req` depends only on FSM state and reset.
- If reset asserts mid-operation, all state returns to reset values immediately, without waiting for a clock edge.

## Structure
- Package `fetch_pkg` holds:
  - The `fetch_state_t` enum (FETCH, HOLD).
  - The `NOP_INSTR` constant 32'h0000_0013.
  - The `RESET_PC` default.
- Sub-module `if_id_reg`: the IF/ID pipeline register, with load, hold and flush and the same asynchronous active-low reset. The FSM, PC and skid buffer stay in `instr_fetch`.

## Test plan
- Reset, then `imem_ready`=1 every cycle with data = address: `imem_addr` sequence 0, 4, 8; `instr` = 0, 4, 8 one cycle later with `valid_out`=1.
- `stall` high for 3 cycles while a word at 0x8 returns: the FSM enters HOLD and `imem_req`=0. The word at 0x8 appears on `instr` after `stall` drops, followed by 0xC, with nothing lost or duplicated.
- `pc_out`=0x10, `ImmOp`=32'hFFFF_FFF8, `PCsrc`=1: next `imem_addr`=0x08; the in-flight word is dropped and `valid_out`=0 for one cycle.
- `PCsrc`=1 while `valid_out`=0: the PC continues sequentially.
- `flush` and `stall` together while in HOLD: `valid_out`=0, the skid buffer empties, the FSM returns to FETCH, and the PC is unchanged.
- `rst_n` pulsed low mid-stream between clock edges: outputs take reset values immediately, and the first `imem_addr` after release is `RESET_PC`.
